// File: rtl/radio_settings_arbiter_if.sv
// Settings-bus bundle between the per-channel requesters and the shared radio settings arbiter.
// drop_cnt is present only when RADIO_SET_ARB_DROP_CNT_EN is defined.
interface radio_settings_arbiter_if #(
    parameter int NUM_BUSES = 2,
    parameter int AWIDTH    = 8,
    parameter int DWIDTH    = 32
);
    localparam int SW = (NUM_BUSES > 1) ? $clog2(NUM_BUSES) : 1;

    logic [NUM_BUSES-1:0]        in_set_stb;
    logic [NUM_BUSES*AWIDTH-1:0] in_set_addr;
    logic [NUM_BUSES*DWIDTH-1:0] in_set_data;
    logic                        ready;
    logic                        out_set_stb;
    logic [AWIDTH-1:0]           out_set_addr;
    logic [DWIDTH-1:0]           out_set_data;
    logic [SW-1:0]               out_set_src;
    logic [NUM_BUSES-1:0]        pending;
    logic [NUM_BUSES-1:0]        overflow;
`ifdef RADIO_SET_ARB_DROP_CNT_EN
    logic [16*NUM_BUSES-1:0]     drop_cnt;

    modport master (
        output in_set_stb, in_set_addr, in_set_data, ready,
        input  out_set_stb, out_set_addr, out_set_data, out_set_src, pending, overflow, drop_cnt
    );
    modport slave (
        input  in_set_stb, in_set_addr, in_set_data, ready,
        output out_set_stb, out_set_addr, out_set_data, out_set_src, pending, overflow, drop_cnt
    );
`else
    modport master (
        output in_set_stb, in_set_addr, in_set_data, ready,
        input  out_set_stb, out_set_addr, out_set_data, out_set_src, pending, overflow
    );
    modport slave (
        input  in_set_stb, in_set_addr, in_set_data, ready,
        output out_set_stb, out_set_addr, out_set_data, out_set_src, pending, overflow
    );
`endif
endinterface

// File: rtl/radio_settings_arbiter.sv
// Round-robin arbiter sharing one radio settings bus among NUM_BUSES requesters, 2-deep FIFO each.
// Optional per-bus saturating drop counters: define RADIO_SET_ARB_DROP_CNT_EN.
module radio_settings_arbiter #(
    parameter int NUM_BUSES = 2,
    parameter int AWIDTH    = 8,
    parameter int DWIDTH    = 32
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    clear,
    radio_settings_arbiter_if.slave bus
);
    localparam int SW = (NUM_BUSES > 1) ? $clog2(NUM_BUSES) : 1;
    localparam int EW = AWIDTH + DWIDTH;

    logic [EW-1:0]        fifo_mem [NUM_BUSES][2];
    logic [1:0]           fifo_cnt [NUM_BUSES];
    logic [SW-1:0]        rr_ptr;

    logic [NUM_BUSES-1:0] req;
    logic [NUM_BUSES-1:0] pop;
    logic [NUM_BUSES-1:0] push;
    logic [NUM_BUSES-1:0] drop;
    logic                 grant_vld;
    logic [SW-1:0]        grant_idx;
    logic [EW-1:0]        grant_entry;
    int                   scan_idx;

    always_comb begin
        req         = '0;
        pop         = '0;
        push        = '0;
        drop        = '0;
        grant_vld   = 1'b0;
        grant_idx   = '0;
        grant_entry = '0;
        scan_idx    = 0;

        // An idle bus strobing this cycle is eligible, so an empty FIFO is bypassed.
        for (int i = 0; i < NUM_BUSES; i++)
            req[i] = !clear && ((fifo_cnt[i] != 2'd0) || bus.in_set_stb[i]);

        // Scan from the far end so the last hit is the first bus in order from rr_ptr.
        if (bus.ready && !clear) begin
            for (int k = NUM_BUSES - 1; k >= 0; k--) begin
                scan_idx = int'(rr_ptr) + k;
                if (scan_idx >= NUM_BUSES)
                    scan_idx = scan_idx - NUM_BUSES;
                if (req[scan_idx]) begin
                    grant_vld = 1'b1;
                    grant_idx = SW'(scan_idx);
                end
            end
        end

        for (int i = 0; i < NUM_BUSES; i++) begin
            pop[i] = grant_vld && (grant_idx == SW'(i));
            if (bus.in_set_stb[i] && !clear) begin
                if ((fifo_cnt[i] != 2'd2) || pop[i])
                    push[i] = 1'b1;
                else
                    drop[i] = 1'b1;
            end
            if (pop[i])
                grant_entry = (fifo_cnt[i] == 2'd0)
                            ? {bus.in_set_addr[AWIDTH*i +: AWIDTH], bus.in_set_data[DWIDTH*i +: DWIDTH]}
                            : fifo_mem[i][0];
        end
    end

    // Storage carries no reset; fifo_cnt alone defines validity.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_BUSES; i++) begin
            if (pop[i])
                fifo_mem[i][0] <= fifo_mem[i][1];
            if (push[i]) begin
                if ((fifo_cnt[i] == 2'd2) || ((fifo_cnt[i] == 2'd1) && !pop[i]))
                    fifo_mem[i][1] <= {bus.in_set_addr[AWIDTH*i +: AWIDTH], bus.in_set_data[DWIDTH*i +: DWIDTH]};
                else if (!pop[i] || (fifo_cnt[i] != 2'd0))
                    fifo_mem[i][0] <= {bus.in_set_addr[AWIDTH*i +: AWIDTH], bus.in_set_data[DWIDTH*i +: DWIDTH]};
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_BUSES; i++)
                fifo_cnt[i] <= 2'd0;
            rr_ptr           <= '0;
            bus.out_set_stb  <= 1'b0;
            bus.out_set_addr <= '0;
            bus.out_set_data <= '0;
            bus.out_set_src  <= '0;
            bus.overflow     <= '0;
        end else if (clear) begin
            for (int i = 0; i < NUM_BUSES; i++)
                fifo_cnt[i] <= 2'd0;
            rr_ptr           <= '0;
            bus.out_set_stb  <= 1'b0;
            bus.out_set_addr <= '0;
            bus.out_set_data <= '0;
            bus.out_set_src  <= '0;
            bus.overflow     <= '0;
        end else begin
            for (int i = 0; i < NUM_BUSES; i++)
                fifo_cnt[i] <= 2'(fifo_cnt[i] + {1'b0, push[i]} - {1'b0, pop[i]});
            bus.overflow    <= bus.overflow | drop;
            bus.out_set_stb <= grant_vld;
            if (grant_vld) begin
                bus.out_set_addr <= grant_entry[EW-1 -: AWIDTH];
                bus.out_set_data <= grant_entry[DWIDTH-1:0];
                bus.out_set_src  <= grant_idx;
                rr_ptr           <= (int'(grant_idx) == NUM_BUSES - 1) ? '0 : SW'(grant_idx + 1'b1);
            end
        end
    end

    always_comb begin
        bus.pending = '0;
        for (int i = 0; i < NUM_BUSES; i++)
            bus.pending[i] = (fifo_cnt[i] != 2'd0);
    end

`ifdef RADIO_SET_ARB_DROP_CNT_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bus.drop_cnt <= '0;
        end else if (clear) begin
            bus.drop_cnt <= '0;
        end else begin
            for (int i = 0; i < NUM_BUSES; i++)
                if (drop[i] && (bus.drop_cnt[16*i +: 16] != 16'hFFFF))
                    bus.drop_cnt[16*i +: 16] <= bus.drop_cnt[16*i +: 16] + 16'd1;
        end
    end
`endif
endmodule

// File: tb/tb_radio_settings_arbiter.sv
// Scoreboard bench for radio_settings_arbiter: queue-based reference model plus directed and random traffic.
// Drop-counter checks follow RADIO_SET_ARB_DROP_CNT_EN.
module tb_radio_settings_arbiter;
    localparam int NB = 2;
    localparam int AW = 8;
    localparam int DW = 32;
    localparam int SW = (NB > 1) ? $clog2(NB) : 1;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } item_t;

    typedef struct {
        item_t it;
        int    src;
        int    cyc;
    } exp_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic clear = 1'b0;
    int   cyc = 0;

    int pass_cnt = 0;
    int total_cnt = 0;

    item_t         mq [NB][$];
    exp_t          expq [$];
    int            mptr = 0;
    logic [NB-1:0] movf = '0;
    int            mdrop [NB];
    logic [NB-1:0] exp_pending = '0;
    logic [NB-1:0] exp_ovf = '0;
    int            exp_drop [NB];

    radio_settings_arbiter_if #(.NUM_BUSES(NB), .AWIDTH(AW), .DWIDTH(DW)) bus ();

    radio_settings_arbiter #(.NUM_BUSES(NB), .AWIDTH(AW), .DWIDTH(DW)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (clear),
        .bus     (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total_cnt++;
        if (act === req)
            pass_cnt++;
        else
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    endfunction

    task automatic model_reset();
        for (int b = 0; b < NB; b++) begin
            mq[b].delete();
            mdrop[b] = 0;
        end
        mptr = 0;
        movf = '0;
    endtask

    // Reference: grant the first bus (from mptr) with queued data or a fresh strobe;
    // it gives up its oldest write, then every remaining strobe joins a queue of at most two.
    task automatic model_step(input logic [NB-1:0] stb, input logic [NB*AW-1:0] a,
                              input logic [NB*DW-1:0] d, input logic rdy, input logic clr);
        int    g;
        int    b;
        item_t it;
        exp_t  e;
        if (clr) begin
            model_reset();
            return;
        end
        g = -1;
        if (rdy)
            for (int k = 0; k < NB; k++) begin
                b = (mptr + k) % NB;
                if (g < 0 && (mq[b].size() > 0 || stb[b]))
                    g = b;
            end
        for (int i = 0; i < NB; i++) begin
            it.a = a[AW*i +: AW];
            it.d = d[DW*i +: DW];
            if (i == g) begin
                if (mq[i].size() > 0) begin
                    e.it = mq[i].pop_front();
                    if (stb[i])
                        mq[i].push_back(it);
                end else begin
                    e.it = it;
                end
                e.src = i;
                e.cyc = cyc + 1;
                expq.push_back(e);
            end else if (stb[i]) begin
                if (mq[i].size() < 2) begin
                    mq[i].push_back(it);
                end else begin
                    movf[i] = 1'b1;
                    if (mdrop[i] < 65535)
                        mdrop[i]++;
                end
            end
        end
        if (g >= 0)
            mptr = (g + 1) % NB;
    endtask

    task automatic snap();
        for (int b = 0; b < NB; b++) begin
            exp_pending[b] = (mq[b].size() > 0);
            exp_drop[b]    = mdrop[b];
        end
        exp_ovf = movf;
    endtask

    task automatic drive(input logic [NB-1:0] stb, input logic [NB*AW-1:0] a,
                         input logic [NB*DW-1:0] d, input logic rdy, input logic clr);
        bus.in_set_stb  = stb;
        bus.in_set_addr = a;
        bus.in_set_data = d;
        bus.ready       = rdy;
        clear           = clr;
        if (reset_n)
            model_step(stb, a, d, rdy, clr);
        else
            model_reset();
        @(posedge clk);
        #1;
        snap();
    endtask

    task automatic idle(input int n, input logic rdy);
        for (int i = 0; i < n; i++)
            drive('0, '0, '0, rdy, 1'b0);
    endtask

    task automatic one(input int b, input logic [AW-1:0] a, input logic [DW-1:0] d, input logic rdy);
        logic [NB-1:0]    s;
        logic [NB*AW-1:0] av;
        logic [NB*DW-1:0] dv;
        s = '0;
        av = '0;
        dv = '0;
        s[b] = 1'b1;
        av[AW*b +: AW] = a;
        dv[DW*b +: DW] = d;
        drive(s, av, dv, rdy, 1'b0);
    endtask

    task automatic pair(input logic [AW-1:0] a0, input logic [AW-1:0] a1, input logic rdy);
        drive(2'b11, {a1, a0}, {32'h1111_0000 | DW'(a1), 32'h0000_1111 | DW'(a0)}, rdy, 1'b0);
    endtask

    always @(negedge clk) begin
        if (reset_n) begin
            chk("pending", 64'(bus.pending), 64'(exp_pending));
            chk("overflow", 64'(bus.overflow), 64'(exp_ovf));
`ifdef RADIO_SET_ARB_DROP_CNT_EN
            for (int b = 0; b < NB; b++)
                chk("drop_cnt", 64'(bus.drop_cnt[16*b +: 16]), 64'(exp_drop[b]));
`endif
            if (expq.size() > 0 && expq[0].cyc == cyc) begin
                exp_t e;
                e = expq.pop_front();
                chk("out_set_stb", 64'(bus.out_set_stb), 64'd1);
                if (bus.out_set_stb) begin
                    chk("out_set_addr", 64'(bus.out_set_addr), 64'(e.it.a));
                    chk("out_set_data", 64'(bus.out_set_data), 64'(e.it.d));
                    chk("out_set_src", 64'(bus.out_set_src), 64'(e.src));
                end
            end else if (bus.out_set_stb) begin
                chk("spurious_out_set_stb", 64'd1, 64'd0);
            end
        end
    end

    initial begin
        logic [NB-1:0]    s;
        logic [NB*AW-1:0] av;
        logic [NB*DW-1:0] dv;
        logic             r;
        logic             c;

        bus.in_set_stb  = '0;
        bus.in_set_addr = '0;
        bus.in_set_data = '0;
        bus.ready       = 1'b0;
        model_reset();
        snap();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_stb", 64'(bus.out_set_stb), 64'd0);
        chk("rst_pending", 64'(bus.pending), 64'd0);
        chk("rst_overflow", 64'(bus.overflow), 64'd0);
        reset_n = 1'b1;
        snap();

        // First grant after reset goes to bus 0 when both strobe together.
        pair(8'h01, 8'h02, 1'b1);
        idle(2, 1'b1);

        // Single write from bus 1.
        one(1, 8'h10, 32'hDEAD_BEEF, 1'b1);
        idle(2, 1'b1);

        // Contention, twice.
        pair(8'h01, 8'h02, 1'b1);
        idle(1, 1'b1);
        pair(8'h01, 8'h02, 1'b1);
        idle(2, 1'b1);

        // Backpressure: third strobe dropped, then drained in order.
        one(0, 8'h21, 32'h0000_0021, 1'b0);
        one(0, 8'h22, 32'h0000_0022, 1'b0);
        one(0, 8'h23, 32'h0000_0023, 1'b0);
        idle(3, 1'b1);

        // Full FIFO with simultaneous pop accepts the new write.
        one(0, 8'h31, 32'h0000_0031, 1'b0);
        one(0, 8'h32, 32'h0000_0032, 1'b0);
        one(0, 8'h33, 32'h0000_0033, 1'b1);
        idle(4, 1'b1);

        // Clear during a queued burst.
        pair(8'h41, 8'h42, 1'b0);
        pair(8'h43, 8'h44, 1'b0);
        pair(8'h45, 8'h46, 1'b0);
        drive('0, '0, '0, 1'b1, 1'b1);
        chk("clear_addr", 64'(bus.out_set_addr), 64'd0);
        chk("clear_pending", 64'(bus.pending), 64'd0);
        idle(3, 1'b1);
        pair(8'h51, 8'h52, 1'b1);
        idle(2, 1'b1);

        // Async reset mid-stream.
        pair(8'h61, 8'h62, 1'b1);
        pair(8'h63, 8'h64, 1'b1);
        reset_n = 1'b0;
        expq.delete();
        model_reset();
        snap();
        #1;
        chk("midrst_stb", 64'(bus.out_set_stb), 64'd0);
        chk("midrst_addr", 64'(bus.out_set_addr), 64'd0);
        chk("midrst_data", 64'(bus.out_set_data), 64'd0);
        chk("midrst_src", 64'(bus.out_set_src), 64'd0);
        chk("midrst_pending", 64'(bus.pending), 64'd0);
        idle(2, 1'b1);
        reset_n = 1'b1;
        snap();
        pair(8'h71, 8'h72, 1'b1);
        idle(2, 1'b1);

        // Random traffic.
        for (int n = 0; n < 3000; n++) begin
            for (int b = 0; b < NB; b++) begin
                s[b] = ($urandom_range(0, 99) < 45);
                av[AW*b +: AW] = AW'($urandom);
                dv[DW*b +: DW] = DW'($urandom);
            end
            r = ($urandom_range(0, 99) < 65);
            c = ($urandom_range(0, 199) == 0);
            drive(s, av, dv, r, c);
        end

        idle(6, 1'b1);
        chk("scoreboard_drained", 64'(expq.size()), 64'd0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: run exceeded time limit, expected completion");
        $fatal(1);
    end
endmodule
